// File: rtl/stage4_inv_if.sv
// stage4_inv_if -- handshake and data bundle for the stage-4 inverse permutation block.
//   Input side : in_valid / in_ready, key bits k2/k3, permuted words w_in..z_in
//   Output side: out_valid / out_ready, restored words a_out..d_out
//   Word packing: byte 0 in bits [7:0], byte 3 in bits [31:24].
//   master modport: upstream/downstream environment driving the block
//   slave  modport: the stage4_inv block itself
interface stage4_inv_if;
  logic        in_valid;
  logic        in_ready;
  logic        k2;
  logic        k3;
  logic [31:0] w_in;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic [31:0] z_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [31:0] c_out;
  logic [31:0] d_out;

  modport master (
    output in_valid, k2, k3, w_in, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, a_out, b_out, c_out, d_out
  );

  modport slave (
    input  in_valid, k2, k3, w_in, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, a_out, b_out, c_out, d_out
  );
endinterface

// File: rtl/stage4_inv.sv
// stage4_inv -- undoes the encrypt-side stage-4 word permutation and buffers the
// restored 128-bit blocks in a 2-entry FIFO.
//   clk      : clock, all state changes on the rising edge
//   reset    : asynchronous, active-high reset
//   bus      : stage4_inv_if.slave (valid/ready input side with k2/k3 and w..z,
//              valid/ready output side with a..d)
//   xfer_cnt : number of completed output transfers since reset (wraps)
module stage4_inv #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  stage4_inv_if.slave      bus,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic             in_ready_reg;
  logic [CNT_W-1:0] xfer_cnt_reg;
  logic [127:0]     mem_reg [2];
  logic [127:0]     perm_block;
  logic [127:0]     head;
  logic             push;
  logic             pop;
  logic             out_valid;

  assign push = bus.in_valid & in_ready_reg;
  assign pop  = out_valid & bus.out_ready;

  // Restore {a,b,c,d} from {w,x,y,z}; key bits only steer this mux and
  // are never stored.
  always_comb begin
    perm_block = {bus.x_in, bus.w_in, bus.z_in, bus.y_in};
    case ({bus.k2, bus.k3})
      2'b00:   perm_block = {bus.x_in, bus.w_in, bus.z_in, bus.y_in};
      2'b10:   perm_block = {bus.z_in, bus.x_in, bus.y_in, bus.w_in};
      2'b01:   perm_block = {bus.w_in, bus.y_in, bus.x_in, bus.z_in};
      default: perm_block = {bus.w_in, bus.z_in, bus.y_in, bus.x_in};
    endcase
  end

  // A pop with an empty FIFO cannot happen (out_valid gates it), and a push
  // with a full FIFO cannot happen (in_ready gates it).
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // in_ready is a flop so it has no combinational path from out_ready and
  // stays low during reset, rising at the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      in_ready_reg <= 1'b0;
      xfer_cnt_reg <= '0;
    end else begin
      count_reg    <= count_next;
      in_ready_reg <= (count_next != 2'd2);
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop) begin
        rd_ptr_reg   <= ~rd_ptr_reg;
        xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= perm_block;
        end
      end
    end
  endgenerate

  assign head      = mem_reg[rd_ptr_reg];
  assign out_valid = (count_reg != 2'd0);

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid;
  // Outputs read as zero whenever no valid block is at the head.
  assign bus.a_out     = out_valid ? head[127:96] : 32'd0;
  assign bus.b_out     = out_valid ? head[95:64]  : 32'd0;
  assign bus.c_out     = out_valid ? head[63:32]  : 32'd0;
  assign bus.d_out     = out_valid ? head[31:0]   : 32'd0;
  assign xfer_cnt      = xfer_cnt_reg;

endmodule

// File: tb/tb_stage4_inv.sv
// tb_stage4_inv -- directed self-checking bench for stage4_inv: key mappings,
// encrypt/decrypt round trip, backpressure, streaming, reset and counter wrap.
module tb_stage4_inv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage4_inv_if bus ();
  stage4_inv_if bus4 ();

  stage4_inv #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .xfer_cnt(xfer_cnt)
  );

  stage4_inv #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .xfer_cnt(xfer_cnt4)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] head_of();
    return {bus.a_out, bus.b_out, bus.c_out, bus.d_out};
  endfunction

  task automatic drive_in(input logic v, input logic k2, input logic k3,
                          input logic [31:0] w, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z);
    bus.in_valid = v;
    bus.k2 = k2;
    bus.k3 = k3;
    bus.w_in = w;
    bus.x_in = x;
    bus.y_in = y;
    bus.z_in = z;
  endtask

  // Encrypt-side stage-4 model: scatter the original words a..d to w..z.
  logic [127:0] cur_orig;
  task automatic new_block();
    logic [31:0] a, b, c, d;
    logic [1:0]  k;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    k = 2'($urandom_range(0, 3));
    cur_orig = {a, b, c, d};
    case (k)
      2'b00:   drive_in(1'b1, 1'b0, 1'b0, b, a, d, c);
      2'b10:   drive_in(1'b1, 1'b1, 1'b0, d, b, c, a);
      2'b01:   drive_in(1'b1, 1'b0, 1'b1, a, c, b, d);
      default: drive_in(1'b1, 1'b1, 1'b1, a, d, c, b);
    endcase
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [127:0] map_exp [4];
  logic [127:0] exp_q [$];
  logic [127:0] bp1, bp2, bp3, exp_blk;
  int rcv, sent, cyc, n;
  logic acc;

  initial begin
    // index = {k2,k3}
    map_exp[0] = 128'h22222222_11111111_44444444_33333333;
    map_exp[2] = 128'h44444444_22222222_33333333_11111111;
    map_exp[1] = 128'h11111111_33333333_22222222_44444444;
    map_exp[3] = 128'h11111111_44444444_33333333_22222222;

    drive_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.k2 = 1'b0; bus4.k3 = 1'b0;
    bus4.w_in = 32'd0; bus4.x_in = 32'd0; bus4.y_in = 32'd0; bus4.z_in = 32'd0;
    bus4.out_ready = 1'b0;

    // ---- reset state
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_in_ready", bus.in_ready, 0);
    check_val("rst_xfer", xfer_cnt, 0);
    check_val("rst_data", head_of(), 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rdy_after_rst", bus.in_ready, 1);

    // ---- key mappings
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, i[1], i[0], 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_val("map_valid", bus.out_valid, 1);
      check_val("map_data", head_of(), map_exp[i]);
      $display("map k2=%0d k3=%0d out=%h", i[1], i[0], head_of());
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_val("map_xfer", xfer_cnt, 16'(i + 1));
      check_val("map_empty_valid", bus.out_valid, 0);
      check_val("map_empty_zero", head_of(), 0);
    end

    // ---- round trip, random keys/data, random out_ready
    rcv = 0; sent = 0; cyc = 0;
    new_block();
    while (rcv < 1000 && cyc < 20000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("rt_underflow", head_of(), 0);
        end else begin
          exp_blk = exp_q.pop_front();
          check_val("rt_data", head_of(), exp_blk);
          $display("rt blk %0d out=%h", rcv, head_of());
        end
        rcv++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        exp_q.push_back(cur_orig);
        sent++;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (sent < 1000) new_block();
        else bus.in_valid = 1'b0;
      end
    end
    check_val("rt_count", rcv, 1000);
    check_val("rt_xfer", xfer_cnt, 1004);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;

    // ---- backpressure (key 00: a=x, b=w, c=z, d=y)
    bp1 = 128'h0B0B0B01_0A0A0A01_0D0D0D01_0C0C0C01;
    bp2 = 128'h0B0B0B02_0A0A0A02_0D0D0D02_0C0C0C02;
    bp3 = 128'h0B0B0B03_0A0A0A03_0D0D0D03_0C0C0C03;
    drive_in(1'b1, 1'b0, 1'b0, 32'h0A0A0A01, 32'h0B0B0B01, 32'h0C0C0C01, 32'h0D0D0D01);
    @(negedge clk);
    check_val("bp_rdy1", bus.in_ready, 1);
    check_val("bp_head1", head_of(), bp1);
    $display("bp push blk1");
    drive_in(1'b1, 1'b0, 1'b0, 32'h0A0A0A02, 32'h0B0B0B02, 32'h0C0C0C02, 32'h0D0D0D02);
    @(negedge clk);
    check_val("bp_full_rdy", bus.in_ready, 0);
    check_val("bp_head1b", head_of(), bp1);
    $display("bp push blk2");
    drive_in(1'b1, 1'b0, 1'b0, 32'h0A0A0A03, 32'h0B0B0B03, 32'h0C0C0C03, 32'h0D0D0D03);
    @(negedge clk);
    check_val("bp_hold_rdy", bus.in_ready, 0);
    check_val("bp_hold_head", head_of(), bp1);
    $display("bp blk3 held upstream");
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_head2", head_of(), bp2);
    check_val("bp_rdy_rise", bus.in_ready, 1);
    $display("bp pop blk1");
    @(negedge clk);
    check_val("bp_head3", head_of(), bp3);
    $display("bp pop blk2 push blk3");
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("bp_drained", bus.out_valid, 0);
    check_val("bp_xfer", xfer_cnt, 1007);
    $display("bp pop blk3");
    bus.out_ready = 1'b0;

    // ---- reset mid-stream with two blocks buffered
    drive_in(1'b1, 1'b1, 1'b1, 32'h5555AAAA, 32'h6666BBBB, 32'h7777CCCC, 32'h8888DDDD);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("rs_full_rdy", bus.in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check_val("rs_valid", bus.out_valid, 0);
    check_val("rs_data", head_of(), 0);
    check_val("rs_xfer", xfer_cnt, 0);
    check_val("rs_rdy", bus.in_ready, 0);
    $display("rst asserted with 2 buffered");
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rs_no_stale", bus.out_valid, 0);
    end
    check_val("rs_rdy_back", bus.in_ready, 1);

    // ---- full-rate streaming, key 11 (w=a, x=d, y=c, z=b)
    for (int e = 0; e <= 50; e++) begin
      if (e > 0) begin
        check_val("st_valid", bus.out_valid, 1);
        check_val("st_rdy", bus.in_ready, 1);
        check_val("st_data", head_of(),
                  {32'hA0000000 + 32'(e - 1), 32'hB0000000 + 32'(e - 1),
                   32'hC0000000 + 32'(e - 1), 32'hD0000000 + 32'(e - 1)});
      end
      drive_in(e < 50, 1'b1, 1'b1, 32'hA0000000 + 32'(e), 32'hD0000000 + 32'(e),
               32'hC0000000 + 32'(e), 32'hB0000000 + 32'(e));
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    check_val("st_xfer", xfer_cnt, 50);
    check_val("st_empty", bus.out_valid, 0);
    $display("stream 50 done xfer=%0d", xfer_cnt);
    bus.out_ready = 1'b0;

    // ---- counter wrap on the 4-bit instance
    bus4.in_valid = 1'b1;
    bus4.out_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 17 && cyc < 100) begin
      #1;
      if (bus4.out_valid && bus4.out_ready) n++;
      @(negedge clk);
      cyc++;
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b0;
    check_val("wrap_n", n, 17);
    check_val("wrap_xfer", xfer_cnt4, 1);
    $display("wrap 17 transfers xfer4=%0d", xfer_cnt4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
